move_repeat_ctrl: RTL

MOVE_REPEAT_CTRL -- requirements
Module: move_repeat_ctrl

---
 rtl/move_repeat_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/move_repeat_ctrl.sv
// rtl/move_repeat_ctrl.sv - debounced move buttons with auto-repeat events, pending/mask/irq over Avalon-MM
// Auto-repeat (DELAY/REPEAT states and their counters) is built only when MOVE_REPEAT_AUTOREPEAT_EN is defined;
// otherwise each debounced press yields exactly one event.
module move_repeat_ctrl #(
   parameter int NUM_BTN      = 4,
   parameter int DEBOUNCE_CYC = 50000,
   parameter int DAS_CYC      = 8000000,
   parameter int ARR_CYC      = 2000000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         address,
   input  logic               write,
   input  logic [31:0]        writedata,
   output logic [31:0]        readdata,
   input  logic [NUM_BTN-1:0] in_port,
   output logic               irq
);

   localparam logic [31:0] DEB_LAST = 32'(DEBOUNCE_CYC - 1);

   logic [NUM_BTN-1:0] sync1_q, sync1_d;
   logic [NUM_BTN-1:0] sync2_q, sync2_d;
   logic [NUM_BTN-1:0] level_q, level_d;
   logic [NUM_BTN-1:0] prev_q, prev_d;
   logic [31:0]        db_cnt_q [NUM_BTN];
   logic [31:0]        db_cnt_d [NUM_BTN];
   logic [NUM_BTN-1:0] pend_q, pend_d;
   logic [NUM_BTN-1:0] mask_q, mask_d;
   logic [7:0]         evcnt_q, evcnt_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               irq_q, irq_d;

   logic [NUM_BTN-1:0] rise;
   logic [NUM_BTN-1:0] event_vec;
   logic [NUM_BTN-1:0] w1c_vec;
   logic               unused_wdata;

   assign unused_wdata = ^writedata[31:NUM_BTN];
   assign rise         = level_q & ~prev_q;
   assign readdata     = rdata_q;
   assign irq          = irq_q;

   // Synchronize raw buttons, then accept a level change only after it has persisted long enough.
   always_comb begin
      sync1_d = in_port;
      sync2_d = sync1_q;
      level_d = level_q;
      prev_d  = level_q;
      for (int i = 0; i < NUM_BTN; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != level_q[i]) begin
            if (db_cnt_q[i] == DEB_LAST) begin
               level_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 32'd1;
            end
         end
      end
   end

   // Input pipeline and debounce state.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         level_q <= '0;
         prev_q  <= '0;
         for (int i = 0; i < NUM_BTN; i++) begin
            db_cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         prev_q  <= prev_d;
         for (int i = 0; i < NUM_BTN; i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
         end
      end
   end

`ifdef MOVE_REPEAT_AUTOREPEAT_EN
   localparam logic [31:0] DAS_LAST = 32'(DAS_CYC - 1);
   localparam logic [31:0] ARR_LAST = 32'(ARR_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   state_t      state_q   [NUM_BTN];
   state_t      state_d   [NUM_BTN];
   logic [31:0] rpt_cnt_q [NUM_BTN];
   logic [31:0] rpt_cnt_d [NUM_BTN];

   // Per-button press/delay/repeat sequencing; a release always wins and emits nothing.
   always_comb begin
      event_vec = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         state_d[i]   = state_q[i];
         rpt_cnt_d[i] = rpt_cnt_q[i];
         case (state_q[i])
            ST_IDLE: begin
               if (rise[i]) begin
                  event_vec[i] = 1'b1;
                  state_d[i]   = ST_DELAY;
                  rpt_cnt_d[i] = '0;
               end
            end
            ST_DELAY: begin
               if (!level_q[i]) begin
                  state_d[i]   = ST_IDLE;
                  rpt_cnt_d[i] = '0;
               end else if (rpt_cnt_q[i] == DAS_LAST) begin
                  event_vec[i] = 1'b1;
                  state_d[i]   = ST_REPEAT;
                  rpt_cnt_d[i] = '0;
               end else begin
                  rpt_cnt_d[i] = rpt_cnt_q[i] + 32'd1;
               end
            end
            ST_REPEAT: begin
               if (!level_q[i]) begin
                  state_d[i]   = ST_IDLE;
                  rpt_cnt_d[i] = '0;
               end else if (rpt_cnt_q[i] == ARR_LAST) begin
                  event_vec[i] = 1'b1;
                  rpt_cnt_d[i] = '0;
               end else begin
                  rpt_cnt_d[i] = rpt_cnt_q[i] + 32'd1;
               end
            end
            default: begin
               state_d[i]   = ST_IDLE;
               rpt_cnt_d[i] = '0;
            end
         endcase
      end
   end

   // Repeat FSM state and counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_BTN; i++) begin
            state_q[i]   <= ST_IDLE;
            rpt_cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            state_q[i]   <= state_d[i];
            rpt_cnt_q[i] <= rpt_cnt_d[i];
         end
      end
   end
`else
   localparam int unused_timing = DAS_CYC + ARR_CYC;

   // Without auto-repeat, only the debounced press edge produces an event.
   always_comb begin
      event_vec = rise;
   end
`endif

   // Register file: sticky pending with event priority over clear, mask, event count, read mux.
   always_comb begin
      w1c_vec = '0;
      mask_d  = mask_q;
      if (write && (address == 2'd1)) begin
         w1c_vec = writedata[NUM_BTN-1:0];
      end
      if (write && (address == 2'd2)) begin
         mask_d = writedata[NUM_BTN-1:0];
      end
      pend_d  = (pend_q & ~w1c_vec) | event_vec;
      evcnt_d = evcnt_q + {7'd0, |event_vec};
      irq_d   = |(pend_q & mask_q);
      case (address)
         2'd0:    rdata_d = {{(32-NUM_BTN){1'b0}}, level_q};
         2'd1:    rdata_d = {{(32-NUM_BTN){1'b0}}, pend_q};
         2'd2:    rdata_d = {{(32-NUM_BTN){1'b0}}, mask_q};
         default: rdata_d = {24'd0, evcnt_q};
      endcase
   end

   // Register file state.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q  <= '0;
         mask_q  <= '0;
         evcnt_q <= '0;
         rdata_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         evcnt_q <= evcnt_d;
         rdata_q <= rdata_d;
         irq_q   <= irq_d;
      end
   end

endmodule
